// File: rtl/counter8_checker_if.sv
// Monitor bus between an 8-bit loadable up-counter and its checker.
// The checker owns the slave side; whoever drives the counter signals uses master.
interface counter8_checker_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 mon_rst_ni;
    logic                 en_i;
    logic                 load_i;
    logic [WIDTH-1:0]     data_i;
    logic [WIDTH-1:0]     cnt_i;
    logic                 locked_o;
    logic                 err_o;
    logic                 wrap_o;
    logic                 fault_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;
    logic [7:0]           wrap_cnt_o;

    modport master (
        output mon_rst_ni, en_i, load_i, data_i, cnt_i,
        input  locked_o, err_o, wrap_o, fault_o, err_cnt_o, wrap_cnt_o
    );

    modport slave (
        input  mon_rst_ni, en_i, load_i, data_i, cnt_i,
        output locked_o, err_o, wrap_o, fault_o, err_cnt_o, wrap_cnt_o
    );
endinterface

// File: rtl/counter8_checker.sv
// Passive scoreboard for the 8-bit loadable up-counter: predicts each count, flags
// mismatches/rollovers, latches a fault. COUNTER8_CHECKER_WRAP_CNT_EN adds a wrap counter.
module counter8_checker #(
    parameter int WIDTH     = 8,
    parameter int MAX_ERR   = 3,
    parameter int ERR_CNT_W = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    counter8_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOCKED, FAULT} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       MAX_ERR_C = 4'(MAX_ERR);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t               state_q;
    logic [WIDTH-1:0]     pred_q, pred_d;
    logic                 arm_q, arm_d;
    logic [3:0]           consec_q;
    logic                 locked_q, err_q, wrap_q, fault_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [WIDTH-1:0]     expected;
    logic                 mismatch;

    // Prediction is built from the observed count, so one glitch resyncs instead of cascading.
    always_comb begin
        pred_d = bus.cnt_i;
        if (!bus.mon_rst_ni)  pred_d = '0;
        else if (bus.load_i)  pred_d = bus.data_i;
        else if (bus.en_i)    pred_d = bus.cnt_i + 1'b1;
    end

    assign arm_d    = bus.mon_rst_ni && !bus.load_i && bus.en_i && (bus.cnt_i == CNT_MAX);
    // The counter's reset is asynchronous, so a low reset in this sample forces 0.
    assign expected = bus.mon_rst_ni ? pred_q : '0;
    assign mismatch = (bus.cnt_i != expected);

`ifdef COUNTER8_CHECKER_WRAP_CNT_EN
    logic [7:0] wrap_cnt_q;
    assign bus.wrap_cnt_o = wrap_cnt_q;
`else
    assign bus.wrap_cnt_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pred_q    <= '0;
            arm_q     <= 1'b0;
            consec_q  <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            fault_q   <= 1'b0;
            err_cnt_q <= '0;
`ifdef COUNTER8_CHECKER_WRAP_CNT_EN
            wrap_cnt_q <= '0;
`endif
        end else begin
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pred_q   <= pred_d;
                    arm_q    <= arm_d;
                    locked_q <= 1'b1;
                    state_q  <= LOCKED;
                end
                LOCKED: begin
                    pred_q <= pred_d;
                    arm_q  <= arm_d;
                    if (mismatch) begin
                        err_q     <= 1'b1;
                        err_cnt_q <= sat_inc(err_cnt_q);
                        consec_q  <= consec_q + 4'd1;
                        if (consec_q + 4'd1 == MAX_ERR_C) begin
                            state_q  <= FAULT;
                            fault_q  <= 1'b1;
                            locked_q <= 1'b0;
                        end
                    end else begin
                        consec_q <= '0;
                        if (arm_q && (bus.cnt_i == '0)) begin
                            wrap_q <= 1'b1;
`ifdef COUNTER8_CHECKER_WRAP_CNT_EN
                            wrap_cnt_q <= wrap_cnt_q + 8'd1;
`endif
                        end
                    end
                end
                FAULT: begin
                    locked_q <= 1'b0;
                    fault_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.locked_o  = locked_q;
    assign bus.err_o     = err_q;
    assign bus.wrap_o    = wrap_q;
    assign bus.fault_o   = fault_q;
    assign bus.err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_counter8_checker.sv
// Bench for counter8_checker: a well-behaved counter drives cnt_i (with injected
// glitches) and a sample-by-sample reference model predicts every checker output.
module tb_counter8_checker;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    counter8_checker_if #(.WIDTH(8), .ERR_CNT_W(8)) bus ();

    counter8_checker #(.WIDTH(8), .MAX_ERR(3), .ERR_CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = waiting for first sample, 1 = comparing, 2 = faulted
    int mode, consec, good_cnt;
    int m_locked, m_err, m_wrap, m_fault, m_err_cnt, m_wrap_cnt;
    int p_rstn, p_load, p_en, p_data, p_cnt;

    function automatic logic [19:0] model_vec();
        return {m_locked[0], m_err[0], m_wrap[0], m_fault[0], m_err_cnt[7:0], m_wrap_cnt[7:0]};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus.locked_o, bus.err_o, bus.wrap_o, bus.fault_o, bus.err_cnt_o, bus.wrap_cnt_o};
    endfunction

    task automatic model_edge(input int r, input int rstn, input int ld, input int en,
                              input int data, input int cnt);
        int exp_cnt;
        m_err  = 0;
        m_wrap = 0;
        if (r != 0) begin
            mode = 0; consec = 0;
            m_locked = 0; m_fault = 0; m_err_cnt = 0; m_wrap_cnt = 0;
            return;
        end
        if (mode == 0) begin
            mode = 1;
            m_locked = 1;
        end else if (mode == 1) begin
            if (rstn == 0 || p_rstn == 0) exp_cnt = 0;
            else if (p_load != 0)         exp_cnt = p_data;
            else if (p_en != 0)           exp_cnt = (p_cnt + 1) % 256;
            else                          exp_cnt = p_cnt;
            if (cnt != exp_cnt) begin
                m_err = 1;
                if (m_err_cnt < 255) m_err_cnt++;
                consec++;
                if (consec == 3) begin
                    mode = 2; m_fault = 1; m_locked = 0;
                end
            end else begin
                consec = 0;
                if (p_cnt == 255 && p_en != 0 && p_load == 0 && p_rstn != 0 && cnt == 0) begin
                    m_wrap = 1;
`ifdef COUNTER8_CHECKER_WRAP_CNT_EN
                    m_wrap_cnt = (m_wrap_cnt + 1) % 256;
`endif
                end
            end
        end
        p_rstn = rstn; p_load = ld; p_en = en; p_data = data; p_cnt = cnt;
    endtask

    // One clock: drive a sample, let the edge happen, advance model and counter.
    task automatic cyc(input int r, input int rstn, input int ld, input int en,
                       input int data, input int force_v);
        int shown;
        @(negedge clk);
        shown = (rstn != 0) ? good_cnt : 0;
        if (force_v >= 0) shown = force_v;
        rst            = r[0];
        bus.mon_rst_ni = rstn[0];
        bus.load_i     = ld[0];
        bus.en_i       = en[0];
        bus.data_i     = data[7:0];
        bus.cnt_i      = shown[7:0];
        @(posedge clk);
        model_edge(r, rstn, ld, en, data, shown);
        if (rstn == 0)    good_cnt = 0;
        else if (ld != 0) good_cnt = data;
        else if (en != 0) good_cnt = (shown + 1) % 256;
        else              good_cnt = shown;
        #1;
    endtask

    task automatic restart();
        cyc(1, 1, 0, 0, 0, -1);
        cyc(0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_reset();
        cyc(1, 1, 0, 0, 0, -1);
        cyc(1, 1, 0, 0, 0, -1);
        n_checks++;
        if (dut_vec() !== 20'h0) begin
            n_errors++; $display("FAIL reset_state: got %h want 00000", dut_vec());
        end
        cyc(0, 0, 0, 0, 0, -1);
        n_checks++;
        if (bus.locked_o !== 1'b1 || bus.err_o !== 1'b0) begin
            n_errors++; $display("FAIL first_lock: got locked=%b err=%b want 1 0", bus.locked_o, bus.err_o);
        end
        cyc(0, 1, 0, 0, 0, -1);
        n_checks++;
        if (dut_vec() !== model_vec() || bus.err_cnt_o !== 8'd0) begin
            n_errors++; $display("FAIL zero_match: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_count();
        int errs = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(0, 1, 0, 1, 0, -1);
            errs += int'(bus.err_o);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++; $display("FAIL count_%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (errs != 0 || good_cnt != 11) begin
            n_errors++; $display("FAIL count_clean: got errs=%0d cnt=%0d want 0 11", errs, good_cnt);
        end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        int base  = int'(bus.wrap_cnt_o);
        cyc(0, 1, 1, 0, 240, -1);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 1, 0, -1);
            wraps += int'(bus.wrap_o);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++; $display("FAIL wrap_%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (wraps != 1) begin
            n_errors++; $display("FAIL wrap_pulses: got %0d want 1", wraps);
        end
        n_checks++;
`ifdef COUNTER8_CHECKER_WRAP_CNT_EN
        if (int'(bus.wrap_cnt_o) != (base + 1) % 256) begin
            n_errors++; $display("FAIL wrap_cnt: got %0d want %0d", bus.wrap_cnt_o, (base + 1) % 256);
        end
`else
        if (bus.wrap_cnt_o !== 8'd0) begin
            n_errors++; $display("FAIL wrap_cnt: got %0d want 0", bus.wrap_cnt_o);
        end
`endif
        // Corner cases that must not produce a wrap: load 0 from max, load+en, reset+load.
        wraps = 0;
        cyc(0, 1, 1, 0, 255, -1);
        cyc(0, 1, 1, 1, 0, -1);
        cyc(0, 1, 1, 1, 255, -1);
        cyc(0, 0, 1, 1, 99, -1);
        wraps += int'(bus.wrap_o);
        cyc(0, 1, 0, 0, 0, -1);
        wraps += int'(bus.wrap_o);
        n_checks++;
        if (wraps != 0 || dut_vec() !== model_vec() || bus.err_o !== 1'b0) begin
            n_errors++; $display("FAIL no_wrap_corner: got wraps=%0d %h want 0 %h", wraps, dut_vec(), model_vec());
        end
    endtask

    task automatic test_glitch();
        int base;
        cyc(0, 1, 1, 0, 3, -1);
        cyc(0, 1, 0, 1, 0, -1);
        cyc(0, 1, 0, 1, 0, -1);
        base = int'(bus.err_cnt_o);
        cyc(0, 1, 0, 1, 0, 7);
        n_checks++;
        if (bus.err_o !== 1'b1 || int'(bus.err_cnt_o) != base + 1) begin
            n_errors++; $display("FAIL glitch_err: got err=%b cnt=%0d want 1 %0d", bus.err_o, bus.err_cnt_o, base + 1);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 1, 0, -1);
            n_checks++;
            if (bus.err_o !== 1'b0 || bus.fault_o !== 1'b0 || dut_vec() !== model_vec()) begin
                n_errors++; $display("FAIL resync_%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_fault();
        restart();
        cyc(0, 1, 0, 0, 0, -1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, good_cnt ^ 'h5A);
        n_checks++;
        if (bus.fault_o !== 1'b1 || bus.err_o !== 1'b1 || bus.err_cnt_o !== 8'd3 || bus.locked_o !== 1'b0) begin
            n_errors++; $display("FAIL fault_set: got %h want fault=1 err=1 err_cnt=3 locked=0", dut_vec());
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom_range(0, 255), $urandom_range(0, 255));
            n_checks++;
            if (bus.fault_o !== 1'b1 || bus.err_cnt_o !== 8'd3 || bus.err_o !== 1'b0 || dut_vec() !== model_vec()) begin
                n_errors++; $display("FAIL fault_sticky_%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        cyc(1, 1, 0, 0, 0, -1);
        n_checks++;
        if (dut_vec() !== 20'h0) begin
            n_errors++; $display("FAIL fault_clear: got %h want 00000", dut_vec());
        end
    endtask

    task automatic test_hold_reset();
        int base;
        cyc(0, 0, 0, 0, 0, -1);
        cyc(0, 1, 1, 0, 12, -1);
        base = int'(bus.err_cnt_o);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, -1);
        n_checks++;
        if (good_cnt != 12 || bus.err_o !== 1'b0) begin
            n_errors++; $display("FAIL hold: got cnt=%0d err=%b want 12 0", good_cnt, bus.err_o);
        end
        cyc(0, 1, 0, 1, 0, -1);
        cyc(0, 0, 0, 1, 0, -1);
        cyc(0, 1, 0, 1, 0, -1);
        n_checks++;
        if (int'(bus.err_cnt_o) != base || dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL mid_reset: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturate();
        restart();
        for (int i = 0; i < 260; i++) begin
            cyc(0, 1, 0, 1, 0, good_cnt ^ 'h01);
            cyc(0, 1, 0, 1, 0, -1);
        end
        n_checks++;
        if (bus.err_cnt_o !== 8'd255 || bus.fault_o !== 1'b0 || dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL saturate: got %h want err_cnt=255 %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int r, rstn, fv;
            r    = ($urandom_range(0, 99) < 2) ? 1 : 0;
            rstn = ($urandom_range(0, 99) < 8) ? 0 : 1;
            fv   = ($urandom_range(0, 99) < 10) ? (((rstn != 0) ? good_cnt : 0) + 1 + $urandom_range(0, 254)) % 256 : -1;
            cyc(r, rstn, ($urandom_range(0, 99) < 15) ? 1 : 0, $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255), fv);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++; $display("FAIL random_%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mon_rst_ni = 1'b1; bus.load_i = 1'b0; bus.en_i = 1'b0;
        bus.data_i = '0; bus.cnt_i = '0;
        mode = 0; consec = 0; good_cnt = 0;
        m_locked = 0; m_err = 0; m_wrap = 0; m_fault = 0; m_err_cnt = 0; m_wrap_cnt = 0;
        p_rstn = 1; p_load = 0; p_en = 0; p_data = 0; p_cnt = 0;
        test_reset();
        test_count();
        test_wrap();
        test_glitch();
        test_fault();
        restart();
        test_hold_reset();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
